// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
package ps2_pkg;

    localparam int unsigned ASCII_W = 8;
    typedef logic [ASCII_W-1:0] ascii_t;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_DEL    = 8'h71;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

endpackage

// File: rtl/ps2_scan_lut.sv
// Combinational set-2 scan code to ASCII translation (US layout).
module ps2_scan_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       extended,
    output ascii_t     ascii,
    output logic       valid
);

    ascii_t base;
    ascii_t alt;
    logic   hit;
    logic   letter;

    // Base (unshifted) character, shifted digit alternative, then case/extended fixups
    always_comb begin
        base  = '0;
        alt   = '0;
        hit   = 1'b1;
        case (code)
            8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
            8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
            8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
            8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
            8'h16: begin base = 8'h31; alt = 8'h21; end
            8'h1E: begin base = 8'h32; alt = 8'h40; end
            8'h26: begin base = 8'h33; alt = 8'h23; end
            8'h25: begin base = 8'h34; alt = 8'h24; end
            8'h2E: begin base = 8'h35; alt = 8'h25; end
            8'h36: begin base = 8'h36; alt = 8'h5E; end
            8'h3D: begin base = 8'h37; alt = 8'h26; end
            8'h3E: begin base = 8'h38; alt = 8'h2A; end
            8'h46: begin base = 8'h39; alt = 8'h28; end
            8'h45: begin base = 8'h30; alt = 8'h29; end
            SC_SPACE: base = 8'h20;
            SC_ENTER: base = 8'h0D;
            SC_BKSP:  base = 8'h08;
            default:  hit  = 1'b0;
        endcase

        letter = (base >= 8'h61) && (base <= 8'h7A);
        ascii  = base;
        valid  = hit;
        if (letter && (shift ^ caps)) begin
            ascii = base - 8'h20;
        end else if ((alt != '0) && shift) begin
            ascii = alt;
        end

        if (extended) begin
            valid = 1'b0;
            ascii = '0;
            if (code == SC_ENTER) begin
                valid = 1'b1;
                ascii = 8'h0D;
            end else if (code == SC_DEL) begin
                valid = 1'b1;
                ascii = 8'h7F;
            end
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: prefix decoding, shift/caps tracking, ASCII output
// into a downstream FIFO with a one-entry pending buffer.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated makes.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SKIP_LEN       = 7
) (
    input  logic       fpga_clk,
    input  logic       rst_n,
    input  logic [7:0] code,
    input  logic       code_valid,
    input  logic       wrfull,
    output logic [7:0] char,
    output logic       wrreq,
    output logic       caps_led,
    output logic       overflow
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam int unsigned SKIP_W = $clog2(SKIP_LEN + 2);

    state_t            state, state_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_n, tmo_inc;
    logic [SKIP_W-1:0] skip_cnt, skip_n;
    logic              shift, shift_n, caps_n, ovf_n, wrreq_n;
    logic              pend_valid, pend_valid_n;
    logic [7:0]        pend_char, pend_char_n, char_n;
    logic              ev_make, ev_break, ev_ext, make_ok, is_shift_code, char_rdy;
    logic              lut_ext, lut_valid;
    ascii_t            lut_ascii;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic              last_valid, last_valid_n, last_ext, last_ext_n;
    logic [7:0]        last_code, last_code_n;
`endif

    // Only makes decoded in EXT are extended; keep this off the comb block to avoid a feedback path
    assign lut_ext = (state == EXT);

    ps2_scan_lut u_lut (
        .code     (code),
        .shift    (shift),
        .caps     (caps_led),
        .extended (lut_ext),
        .ascii    (lut_ascii),
        .valid    (lut_valid)
    );

    // Next-state, key events, modifier tracking and FIFO write/pending logic
    always_comb begin
        state_n      = state;
        tmo_n        = '0;
        tmo_inc      = tmo_cnt + 1'b1;
        skip_n       = skip_cnt;
        shift_n      = shift;
        caps_n       = caps_led;
        ovf_n        = overflow;
        wrreq_n      = 1'b0;
        char_n       = char;
        pend_valid_n = pend_valid;
        pend_char_n  = pend_char;
        ev_make      = 1'b0;
        ev_break     = 1'b0;
        ev_ext       = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        last_valid_n = last_valid;
        last_ext_n   = last_ext;
        last_code_n  = last_code;
`endif

        case (state)
            IDLE: begin
                if (code_valid) begin
                    if (code == SC_EXT) begin
                        state_n = EXT;
                    end else if (code == SC_BREAK) begin
                        state_n = BRK;
                    end else if (code == SC_PAUSE) begin
                        state_n = SKIP;
                        skip_n  = SKIP_W'(SKIP_LEN);
                    end else begin
                        ev_make = 1'b1;
                    end
                end
            end
            EXT: begin
                if (code_valid) begin
                    if (code == SC_BREAK) begin
                        state_n = EXT_BRK;
                    end else begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            BRK: begin
                if (code_valid) begin
                    ev_break = 1'b1;
                    state_n  = IDLE;
                end
            end
            EXT_BRK: begin
                if (code_valid) begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_n  = IDLE;
                end
            end
            SKIP: begin
                if (code_valid) begin
                    skip_n = skip_cnt - 1'b1;
                    if (skip_cnt <= SKIP_W'(1)) begin
                        skip_n  = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A stalled prefix sequence is abandoned silently
        if ((state != IDLE) && !code_valid) begin
            if (32'(tmo_inc) >= TIMEOUT_CYCLES) begin
                state_n = IDLE;
                skip_n  = '0;
            end else begin
                tmo_n = tmo_inc;
            end
        end

        is_shift_code = (code == SC_LSHIFT) || (code == SC_RSHIFT);

`ifdef PS2_TYPEMATIC_FILTER_EN
        make_ok = ev_make && !(last_valid && (last_code == code) && (last_ext == ev_ext));
        if (make_ok) begin
            last_valid_n = 1'b1;
            last_ext_n   = ev_ext;
            last_code_n  = code;
        end
        if (ev_break && last_valid && (last_code == code) && (last_ext == ev_ext)) begin
            last_valid_n = 1'b0;
        end
`else
        make_ok = ev_make;
`endif

        if (make_ok && !ev_ext && is_shift_code) begin
            shift_n = 1'b1;
        end
        if (ev_break && !ev_ext && is_shift_code) begin
            shift_n = 1'b0;
        end
        if (make_ok && !ev_ext && (code == SC_CAPS)) begin
            caps_n = !caps_led;
        end

        // Drain the pending character first; a new one is dropped if the slot was occupied
        char_rdy = make_ok && lut_valid;
        if (pend_valid && !wrfull) begin
            wrreq_n      = 1'b1;
            char_n       = pend_char;
            pend_valid_n = 1'b0;
        end
        if (char_rdy) begin
            if (pend_valid) begin
                ovf_n = 1'b1;
            end else if (!wrfull) begin
                wrreq_n = 1'b1;
                char_n  = lut_ascii;
            end else begin
                pend_valid_n = 1'b1;
                pend_char_n  = lut_ascii;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge fpga_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            skip_cnt   <= '0;
            shift      <= 1'b0;
            caps_led   <= 1'b0;
            overflow   <= 1'b0;
            wrreq      <= 1'b0;
            char       <= 8'h00;
            pend_valid <= 1'b0;
            pend_char  <= 8'h00;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_valid <= 1'b0;
            last_ext   <= 1'b0;
            last_code  <= 8'h00;
`endif
        end else begin
            state      <= state_n;
            tmo_cnt    <= tmo_n;
            skip_cnt   <= skip_n;
            shift      <= shift_n;
            caps_led   <= caps_n;
            overflow   <= ovf_n;
            wrreq      <= wrreq_n;
            char       <= char_n;
            pend_valid <= pend_valid_n;
            pend_char  <= pend_char_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_valid <= last_valid_n;
            last_ext   <= last_ext_n;
            last_code  <= last_code_n;
`endif
        end
    end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, max fpga_clk cycles a prefix state waits for the next code.
REQ-002 SHALL have parameter SKIP_LEN, default 7, number of bytes discarded after an E1 (Pause) prefix.
REQ-003 fpga_clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 code  input  8  scan-code byte from the PS/2 receiver.
REQ-006 code_valid  input  1  one-cycle strobe qualifying code.
REQ-007 wrfull  input  1  downstream FIFO full; write forbidden while high.
REQ-008 char  output  8  ASCII character to downstream FIFO.
REQ-009 wrreq  output  1  one-cycle write strobe qualifying char.
REQ-010 caps_led  output  1  current Caps Lock state.
REQ-011 overflow  output  1  sticky flag: a character was dropped.

Function
REQ-012 Decoder FSM states SHALL be IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (after E1).
REQ-013 In IDLE: E0->EXT, F0->BRK, E1->SKIP (skip counter = SKIP_LEN), other codes are make events processed in place.
REQ-014 In EXT: F0->EXT_BRK; any other code is an extended make, then ->IDLE.
REQ-015 BRK and EXT_BRK: next code is a break event (normal/extended), then ->IDLE; breaks never emit characters.
REQ-016 SKIP: each code_valid decrements counter; at 1->0 transition ->IDLE; no events generated.
REQ-017 Each non-IDLE state SHALL run a timeout counter cleared on state entry and on every code_valid; reaching TIMEOUT_CYCLES forces IDLE with no event.
REQ-018 Shift held SHALL be set by make of 0x12 or 0x59 and cleared by break of either code.
REQ-019 caps_led SHALL toggle on each make of 0x58 (not on break).
REQ-020 Normal makes of letters, digits, space (0x29), enter (0x5A), backspace (0x66) SHALL map to ASCII; letters uppercase iff shift XOR caps_led; digits shifted per US layout when shift held.
REQ-021 Extended make E0 5A SHALL emit 0x0D, E0 71 SHALL emit 0x7F; all other extended and unmapped codes emit nothing.
REQ-022 Character output latency SHALL be 1 cycle: wrreq asserted the cycle after the code_valid that completes the make, when wrfull is low.
REQ-023 If wrfull is high when a character is ready, it SHALL be held in a one-entry pending register and written on the first cycle wrfull is low.
REQ-024 A new character arriving while pending is occupied SHALL be dropped and overflow set; the pending character is preserved.
REQ-025 wrreq SHALL never assert while wrfull is high and SHALL never exceed one cycle per character.
REQ-026 code_valid while not in IDLE-equivalent processing SHALL be consumed every cycle; back-to-back strobes on consecutive cycles are supported.

Reset
REQ-027 With rst_n low at a clock edge: state IDLE, counters 0, shift 0, pending empty, char 8'h00, wrreq 0, caps_led 0, overflow 0.
REQ-028 Reset mid-sequence (e.g. after E0 or inside SKIP) SHALL discard the partial sequence; the first code after reset is decoded from IDLE.

Configuration
REQ-029 Macro PS2_TYPEMATIC_FILTER_EN: when defined, a make identical (code and extended flag) to the last make without an intervening break of it SHALL emit nothing (auto-repeat suppressed); last-make register cleared on reset and on its break.
REQ-030 Without PS2_TYPEMATIC_FILTER_EN every make, including auto-repeats, SHALL be processed normally.

Structure
REQ-031 Package ps2_pkg SHALL hold the FSM state enum, scan-code constants (E0, E1, F0, 12, 59, 58, 5A, 71, 66, 29) and the ASCII width typedef.
REQ-032 Translation SHALL live in combinational sub-module ps2_scan_lut (inputs code, shift, caps, extended; outputs ascii, valid).

Verification
REQ-033 1C -> wrreq one cycle later, char 0x61; 12, 1C -> 0x41; F0 12, 1C -> 0x61.
REQ-034 58, F0 58, 1C -> caps_led 1, char 0x41; then 12, 1C -> 0x61.
REQ-035 E0 71 -> 0x7F; E0 F0 71 -> no wrreq; E1 14 77 E1 F0 14 F0 77 then 1C -> only 0x61.
REQ-036 E0, idle TIMEOUT_CYCLES, then 1C -> 0x61 (not extended); reset during SKIP then 1C -> 0x61.
REQ-037 wrfull high, 1C, 32 -> no wrreq, overflow 1; wrfull low -> single wrreq char 0x61.
REQ-038 With PS2_TYPEMATIC_FILTER_EN: 1C 1C 1C -> one 0x61; F0 1C, 1C -> second 0x61; without macro: three 0x61.
